// File: rtl/gate_resp_checker.sv
// Checks a 2-input gate block's seven responses against the ideal truth table
// over a run of NUM_VEC valid samples, tracking errors, coverage and the first failure.
module gate_resp_checker #(
    parameter int NUM_VEC = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             smp_vld,
    input  logic             a,
    input  logic             b,
    input  logic             not_g,
    input  logic             and_g,
    input  logic             or_g,
    input  logic             nand_g,
    input  logic             nor_g,
    input  logic             xor_g,
    input  logic             xnor_g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [6:0]       err_mask,
    output logic [3:0]       cov,
    output logic [8:0]       first_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LP_NUM_VEC = CNT_W'(NUM_VEC);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_smp_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [6:0]       r_err_mask;
    logic [3:0]       r_cov;
    logic [8:0]       r_first_err;

    logic [6:0]       w_obs;
    logic [6:0]       w_exp;
    logic [6:0]       w_mis;
    logic             w_fail;
    logic             w_accept;
    logic [CNT_W-1:0] w_smp_next;

    assign w_obs      = {not_g, and_g, or_g, nand_g, nor_g, xor_g, xnor_g};
    assign w_exp      = {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    assign w_mis      = w_obs ^ w_exp;
    assign w_fail     = |w_mis;
    assign w_accept   = (r_state == ST_RUN) && smp_vld;
    assign w_smp_next = r_smp_cnt + 1'b1;

    // start clears results from any state, so a sample arriving with it is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_smp_cnt   <= '0;
            r_err_cnt   <= '0;
            r_err_mask  <= '0;
            r_cov       <= '0;
            r_first_err <= '0;
        end else if (start) begin
            r_state     <= ST_RUN;
            r_smp_cnt   <= '0;
            r_err_cnt   <= '0;
            r_err_mask  <= '0;
            r_cov       <= '0;
            r_first_err <= '0;
        end else if (w_accept) begin
            r_smp_cnt       <= w_smp_next;
            r_cov[{a, b}]   <= 1'b1;
            r_err_mask      <= r_err_mask | w_mis;
            if (w_fail) begin
                if (r_err_cnt == '0) begin
                    r_first_err <= {a, b, w_obs};
                end
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
            if (w_smp_next == LP_NUM_VEC) begin
                r_state <= ST_DONE;
            end
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign pass      = done && (r_err_cnt == '0) && (r_cov == 4'hF);
    assign smp_cnt   = r_smp_cnt;
    assign err_cnt   = r_err_cnt;
    assign err_mask  = r_err_mask;
    assign cov       = r_cov;
    assign first_err = r_first_err;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench: two checker configurations share one stimulus stream; a
// truth-table reference model predicts every cycle's results, monitors compare.
module tb_gate_resp_checker;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] smp;
        logic [7:0] err;
        logic [6:0] mask;
        logic [3:0] cov;
        logic [8:0] fe;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n, start, smp_vld, a, b;
    logic not_g, and_g, or_g, nand_g, nor_g, xor_g, xnor_g;

    logic       busy0, done0, pass0;
    logic [7:0] smp0, err0;
    logic [6:0] mask0;
    logic [3:0] cov0;
    logic [8:0] fe0;

    logic       busy1, done1, pass1;
    logic [1:0] smp1, err1;
    logic [6:0] mask1;
    logic [3:0] cov1;
    logic [8:0] fe1;

    int checks   = 0;
    int failures = 0;

    // reference model state, index 0 = default config, 1 = CNT_W=2/NUM_VEC=3
    int       nv[2]  = '{4, 3};
    int       sat[2] = '{255, 3};
    bit       m_run[2], m_fin[2];
    int       m_smp[2], m_err[2];
    bit [6:0] m_mask[2];
    bit [3:0] m_cov[2];
    bit [8:0] m_fe[2];

    snap_t q0[$];
    snap_t q1[$];

    always #5 clk = ~clk;

    gate_resp_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .smp_vld(smp_vld), .a(a), .b(b),
        .not_g(not_g), .and_g(and_g), .or_g(or_g), .nand_g(nand_g), .nor_g(nor_g),
        .xor_g(xor_g), .xnor_g(xnor_g),
        .busy(busy0), .done(done0), .pass(pass0), .smp_cnt(smp0), .err_cnt(err0),
        .err_mask(mask0), .cov(cov0), .first_err(fe0)
    );

    gate_resp_checker #(.NUM_VEC(3), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .smp_vld(smp_vld), .a(a), .b(b),
        .not_g(not_g), .and_g(and_g), .or_g(or_g), .nand_g(nand_g), .nor_g(nor_g),
        .xor_g(xor_g), .xnor_g(xnor_g),
        .busy(busy1), .done(done1), .pass(pass1), .smp_cnt(smp1), .err_cnt(err1),
        .err_mask(mask1), .cov(cov1), .first_err(fe1)
    );

    // ideal gate responses from truth-table arithmetic
    function automatic bit [6:0] good(input bit ia, input bit ib);
        int s;
        bit [6:0] v;
        s = int'(ia) + int'(ib);
        v[6] = (s - int'(ib)) == 0;
        v[5] = s == 2;
        v[4] = s >= 1;
        v[3] = s != 2;
        v[2] = s == 0;
        v[1] = s == 1;
        v[0] = s != 1;
        return v;
    endfunction

    task automatic model_step(input int k);
        snap_t    s;
        bit [6:0] obs, mis;
        if (!rst_n || start) begin
            m_run[k] = rst_n;
            m_fin[k] = 1'b0;
            m_smp[k] = 0;
            m_err[k] = 0;
            m_mask[k] = '0;
            m_cov[k] = '0;
            m_fe[k] = '0;
        end else if (m_run[k] && smp_vld) begin
            obs = {not_g, and_g, or_g, nand_g, nor_g, xor_g, xnor_g};
            mis = obs ^ good(a, b);
            m_smp[k]++;
            m_cov[k][{a, b}] = 1'b1;
            m_mask[k] |= mis;
            if (mis != 0) begin
                if (m_err[k] == 0) m_fe[k] = {a, b, obs};
                if (m_err[k] < sat[k]) m_err[k]++;
            end
            if (m_smp[k] == nv[k]) begin
                m_run[k] = 1'b0;
                m_fin[k] = 1'b1;
            end
        end
        s.busy = m_run[k];
        s.done = m_fin[k];
        s.pass = m_fin[k] && m_err[k] == 0 && m_cov[k] == 4'hF;
        s.smp  = 8'(m_smp[k]);
        s.err  = 8'(m_err[k]);
        s.mask = m_mask[k];
        s.cov  = m_cov[k];
        s.fe   = m_fe[k];
        if (k == 0) q0.push_back(s);
        else        q1.push_back(s);
    endtask

    // apply inputs for one cycle; expectations are pushed at the sampling edge
    task automatic drive(input bit r, input bit s, input bit v, input bit ia, input bit ib,
                         input bit [6:0] obs);
        rst_n = r; start = s; smp_vld = v; a = ia; b = ib;
        {not_g, and_g, or_g, nand_g, nor_g, xor_g, xnor_g} = obs;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic sample(input bit ia, input bit ib, input int mode);
        bit [6:0] o;
        o = good(ia, ib);
        if (mode == 1) o[1] = 1'b0;
        if (mode == 2) o = ~o;
        drive(1, 0, 1, ia, ib, o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 7'h0);
    endtask

    task automatic expect_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        snap_t e, g;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            g = {busy0, done0, pass0, smp0, err0, mask0, cov0, fe0};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL dut0_snapshot t=%0t actual=%h required=%h", $time, g, e);
            end
        end
    end

    always @(negedge clk) begin
        snap_t e, g;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            g = {busy1, done1, pass1, 6'b0, smp1, 6'b0, err1, mask1, cov1, fe1};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL dut1_snapshot t=%0t actual=%h required=%h", $time, g, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit [6:0] o;
        rst_n = 0; start = 0; smp_vld = 0; a = 0; b = 0;
        {not_g, and_g, or_g, nand_g, nor_g, xor_g, xnor_g} = '0;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 7'h0);
        drive(0, 1, 1, 1, 1, 7'h7F);

        // samples while idle are ignored; then a clean full-coverage run
        sample(1, 0, 0);
        drive(1, 1, 0, 0, 0, 7'h0);
        sample(0, 0, 0); sample(0, 1, 0); sample(1, 0, 0); sample(1, 1, 0);
        @(negedge clk);
        expect_val("clean_done", int'(done0), 1);
        expect_val("clean_pass", int'(pass0), 1);
        expect_val("clean_smp_cnt", int'(smp0), 4);
        sample(0, 1, 2);
        idle(2);

        // xor stuck at 0
        drive(1, 1, 0, 0, 0, 7'h0);
        sample(0, 0, 1); sample(0, 1, 1); sample(1, 0, 1); sample(1, 1, 1);
        @(negedge clk);
        expect_val("xor0_err_cnt", int'(err0), 2);
        expect_val("xor0_err_mask", int'(mask0), 2);
        expect_val("xor0_pass", int'(pass0), 0);

        // coverage hole
        drive(1, 1, 0, 0, 0, 7'h0);
        sample(0, 0, 0); sample(0, 0, 0); sample(0, 1, 0); sample(0, 1, 0);
        @(negedge clk);
        expect_val("hole_cov", int'(cov0), 3);
        expect_val("hole_pass", int'(pass0), 0);

        // reset mid-run, then start with a simultaneous sample
        drive(1, 1, 0, 0, 0, 7'h0);
        sample(1, 1, 1); sample(0, 1, 0);
        drive(0, 0, 1, 1, 0, 7'h0);
        drive(1, 1, 1, 1, 0, 7'h0);
        @(negedge clk);
        expect_val("startvld_smp_cnt", int'(smp0), 0);
        expect_val("startvld_busy", int'(busy0), 1);

        // inverted outputs with gaps; dut1 completes after three samples
        drive(1, 1, 0, 0, 0, 7'h0);
        sample(0, 0, 2); idle(3);
        sample(1, 0, 2); idle(2);
        sample(1, 1, 2); idle(1);
        expect_val("inv_err_cnt_w2", int'(err1), 3);
        expect_val("inv_done_w2", int'(done1), 1);
        sample(0, 1, 2);
        drive(1, 1, 0, 0, 0, 7'h0);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            o = good(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            o = good(a, b);
            if ($urandom_range(0, 5) == 0) o[$urandom_range(0, 6)] ^= 1'b1;
            drive($urandom_range(0, 59) != 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 3) != 0, a, b, o);
        end
        idle(2);

        repeat (2) @(negedge clk);
        expect_val("q0_drained", q0.size(), 0);
        expect_val("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
